// File: rtl/csr_xbar_pkg.sv
// csr_xbar_pkg: FSM state encoding and response status constants shared by the
// CSR router and its address decoder.
package csr_xbar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RSP
  } xbar_state_e;

  localparam int STATUS_W = 3;

  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  // Router-generated statuses always carry the exception bit.
  function automatic logic [STATUS_W-1:0] exc_status(input logic [1:0] cause);
    return {1'b1, cause};
  endfunction

endpackage

// File: rtl/csr_xbar_decode.sv
// csr_xbar_decode: combinational CSR address decode against the per-target
// base/limit table; lowest matching index wins, miss flags an unmapped address.
module csr_xbar_decode
  import csr_xbar_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int N_TGT      = 4,
  parameter logic [N_TGT*ADDR_WIDTH-1:0] TGT_BASE  = {N_TGT{{ADDR_WIDTH{1'b0}}}},
  parameter logic [N_TGT*ADDR_WIDTH-1:0] TGT_LIMIT = {N_TGT{{ADDR_WIDTH{1'b0}}}}
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [N_TGT-1:0]      hit,
  output logic                  miss
);

  logic found;

  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < N_TGT; i++) begin
      if (!found &&
          (addr >= TGT_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
          (addr <= TGT_LIMIT[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = !found;
  end

endmodule

// File: rtl/csr_xbar.sv
// csr_xbar: routes one CSR access at a time to a single target and returns its
// response. Define CSR_XBAR_TIMEOUT_EN to turn silent targets into a timeout exception.
module csr_xbar
  import csr_xbar_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int REG_WIDTH   = 32,
  parameter int N_TGT       = 4,
  parameter logic [N_TGT*ADDR_WIDTH-1:0] TGT_BASE  = {N_TGT{{ADDR_WIDTH{1'b0}}}},
  parameter logic [N_TGT*ADDR_WIDTH-1:0] TGT_LIMIT = {N_TGT{{ADDR_WIDTH{1'b0}}}},
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        csr_valid,
  output logic                        csr_ready,
  input  logic [1:0]                  csr_op,
  input  logic [2:0]                  csr_funct3,
  input  logic [4:0]                  csr_imm,
  input  logic [REG_WIDTH-1:0]        rs1_val,
  input  logic [ADDR_WIDTH-1:0]       csr_addr,
  output logic                        csr_rvalid,
  output logic [REG_WIDTH-1:0]        csr_rdata,
  output logic [STATUS_W-1:0]         csr_reg_rsp,
  input  logic                        csr_rrsp,
  output logic [N_TGT-1:0]            tgt_reg_en,
  output logic [ADDR_WIDTH-1:0]       tgt_addr,
  output logic [4:0]                  tgt_csr_imm,
  output logic [REG_WIDTH-1:0]        tgt_rs1_val,
  output logic [2:0]                  tgt_funct3,
  output logic [1:0]                  tgt_reg_op,
  input  logic [N_TGT-1:0]            tgt_rvalid,
  input  logic [N_TGT*REG_WIDTH-1:0]  tgt_rdata,
  input  logic [N_TGT*STATUS_W-1:0]   tgt_act_rsp,
  output logic [N_TGT-1:0]            tgt_rrsp
);

  xbar_state_e          state_q, state_d;
  logic [N_TGT-1:0]     sel_q;
  logic [N_TGT-1:0]     dec_hit;
  logic                 dec_miss;
  logic                 busy;
  logic                 accept;
  logic                 sel_rvalid;
  logic [REG_WIDTH-1:0] sel_rdata;
  logic [STATUS_W-1:0]  sel_rsp;
  logic                 timeout_hit;

  csr_xbar_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .N_TGT      (N_TGT),
    .TGT_BASE   (TGT_BASE),
    .TGT_LIMIT  (TGT_LIMIT)
  ) u_decode (
    .addr (csr_addr),
    .hit  (dec_hit),
    .miss (dec_miss)
  );

  assign busy       = (state_q == ISSUE) || (state_q == WAIT);
  assign accept     = (state_q == IDLE) && csr_valid;
  assign csr_ready  = (state_q == IDLE);
  assign csr_rvalid = (state_q == RSP);
  assign tgt_reg_en = (state_q == ISSUE) ? sel_q : '0;
  assign tgt_rrsp   = busy ? sel_q : '0;

  // Only the selected target's response is visible; others are masked off.
  always_comb begin
    sel_rvalid = busy && |(tgt_rvalid & sel_q);
    sel_rdata  = '0;
    sel_rsp    = '0;
    for (int i = 0; i < N_TGT; i++) begin
      if (sel_q[i]) begin
        sel_rdata = sel_rdata | tgt_rdata[i*REG_WIDTH +: REG_WIDTH];
        sel_rsp   = sel_rsp | tgt_act_rsp[i*STATUS_W +: STATUS_W];
      end
    end
  end

`ifdef CSR_XBAR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  // A response arriving in the expiry cycle takes priority over the timeout.
  assign timeout_hit = busy && !sel_rvalid && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (csr_valid) state_d = dec_miss ? RSP : ISSUE;
      ISSUE, WAIT: state_d = (sel_rvalid || timeout_hit) ? RSP : WAIT;
      RSP:         if (csr_rrsp) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload is latched at accept; the response is frozen on entry to RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      tgt_addr    <= '0;
      tgt_csr_imm <= '0;
      tgt_rs1_val <= '0;
      tgt_funct3  <= '0;
      tgt_reg_op  <= '0;
      csr_rdata   <= '0;
      csr_reg_rsp <= '0;
    end else if (accept) begin
      sel_q       <= dec_hit;
      tgt_addr    <= csr_addr;
      tgt_csr_imm <= csr_imm;
      tgt_rs1_val <= rs1_val;
      tgt_funct3  <= csr_funct3;
      tgt_reg_op  <= csr_op;
      if (dec_miss) begin
        csr_rdata   <= '0;
        csr_reg_rsp <= exc_status(CAUSE_UNMAPPED);
      end
    end else if (sel_rvalid) begin
      csr_rdata   <= sel_rdata;
      csr_reg_rsp <= sel_rsp;
    end else if (timeout_hit) begin
      csr_rdata   <= '0;
      csr_reg_rsp <= exc_status(CAUSE_TIMEOUT);
    end
  end

endmodule

// File: tb/tb_csr_xbar.sv
// tb_csr_xbar: randomized self-checking bench for csr_xbar with two targets
// (0x3A0-0x3EF and 0x300-0x305); timeout cases apply when CSR_XBAR_TIMEOUT_EN is defined.
module tb_csr_xbar;

  localparam int AW = 32;
  localparam int RW = 32;
  localparam int NT = 2;
  localparam int TO = 4;
  localparam logic [NT*AW-1:0] BASES  = {32'h0000_0300, 32'h0000_03A0};
  localparam logic [NT*AW-1:0] LIMITS = {32'h0000_0305, 32'h0000_03EF};

  logic           clk = 1'b0;
  logic           rst_n;
  logic           csr_valid;
  logic           csr_ready;
  logic [1:0]     csr_op;
  logic [2:0]     csr_funct3;
  logic [4:0]     csr_imm;
  logic [RW-1:0]  rs1_val;
  logic [AW-1:0]  csr_addr;
  logic           csr_rvalid;
  logic [RW-1:0]  csr_rdata;
  logic [2:0]     csr_reg_rsp;
  logic           csr_rrsp;
  logic [NT-1:0]  tgt_reg_en;
  logic [AW-1:0]  tgt_addr;
  logic [4:0]     tgt_csr_imm;
  logic [RW-1:0]  tgt_rs1_val;
  logic [2:0]     tgt_funct3;
  logic [1:0]     tgt_reg_op;
  logic [NT-1:0]  tgt_rvalid;
  logic [NT*RW-1:0] tgt_rdata;
  logic [NT*3-1:0]  tgt_act_rsp;
  logic [NT-1:0]  tgt_rrsp;

  int checks = 0;
  int errors = 0;

  logic [31:0] edge_addrs [8];

  csr_xbar #(
    .ADDR_WIDTH  (AW),
    .REG_WIDTH   (RW),
    .N_TGT       (NT),
    .TGT_BASE    (BASES),
    .TGT_LIMIT   (LIMITS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_valid   (csr_valid),
    .csr_ready   (csr_ready),
    .csr_op      (csr_op),
    .csr_funct3  (csr_funct3),
    .csr_imm     (csr_imm),
    .rs1_val     (rs1_val),
    .csr_addr    (csr_addr),
    .csr_rvalid  (csr_rvalid),
    .csr_rdata   (csr_rdata),
    .csr_reg_rsp (csr_reg_rsp),
    .csr_rrsp    (csr_rrsp),
    .tgt_reg_en  (tgt_reg_en),
    .tgt_addr    (tgt_addr),
    .tgt_csr_imm (tgt_csr_imm),
    .tgt_rs1_val (tgt_rs1_val),
    .tgt_funct3  (tgt_funct3),
    .tgt_reg_op  (tgt_reg_op),
    .tgt_rvalid  (tgt_rvalid),
    .tgt_rdata   (tgt_rdata),
    .tgt_act_rsp (tgt_act_rsp),
    .tgt_rrsp    (tgt_rrsp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference address map: first range in the table containing the address, else -1.
  function automatic int modelTarget(input logic [31:0] a);
    logic [31:0] lo [NT];
    logic [31:0] hi [NT];
    lo = '{32'h3A0, 32'h300};
    hi = '{32'h3EF, 32'h305};
    for (int i = 0; i < NT; i++) begin
      if (a >= lo[i] && a <= hi[i]) return i;
    end
    return -1;
  endfunction

  // One full access: accept, target reply after 'delay' cycles (-1 = silent),
  // core stalls 'hold' cycles in RSP, then acknowledges.
  task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] op,
                               input logic [31:0] rs1, input logic [2:0] f3,
                               input logic [4:0] imm, input int delay,
                               input logic [31:0] rdat, input logic [2:0] st,
                               input int hold);
    int          tgt;
    int          exp_cyc;
    int          cyc;
    int          waited;
    logic [2:0]  exp_st;
    logic [31:0] exp_d;
    logic [NT-1:0] exp_sel;
    tgt = modelTarget(addr);
    exp_sel = (tgt >= 0) ? NT'(1 << tgt) : '0;
    if (tgt < 0) begin
      exp_st = 3'b101; exp_d = '0; exp_cyc = 1;
    end
`ifdef CSR_XBAR_TIMEOUT_EN
    else if (delay < 0 || delay > TO) begin
      exp_st = 3'b110; exp_d = '0; exp_cyc = TO + 1;
    end
`endif
    else begin
      exp_st = st; exp_d = rdat; exp_cyc = delay + 1;
    end

    waited = 0;
    while (!csr_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready_before_accept", 64'(csr_ready), 64'(1));
    csr_valid = 1'b1; csr_addr = addr; csr_op = op; rs1_val = rs1;
    csr_funct3 = f3; csr_imm = imm;
    @(negedge clk);
    csr_valid = 1'b0; csr_addr = $urandom; rs1_val = $urandom;
    csr_op = 2'($urandom); csr_funct3 = 3'($urandom); csr_imm = 5'($urandom);

    checkOutput("tgt_reg_en_c1", 64'(tgt_reg_en), 64'(exp_sel));
    checkOutput("tgt_addr", 64'(tgt_addr), 64'(addr));
    checkOutput("tgt_rs1_val", 64'(tgt_rs1_val), 64'(rs1));
    checkOutput("tgt_funct3", 64'(tgt_funct3), 64'(f3));
    checkOutput("tgt_csr_imm", 64'(tgt_csr_imm), 64'(imm));
    checkOutput("tgt_reg_op", 64'(tgt_reg_op), 64'(op));

    cyc = 1;
    while (!csr_rvalid && cyc < 64) begin
      if (cyc > 1) begin
        checkOutput("tgt_reg_en_wait", 64'(tgt_reg_en), 64'(0));
        checkOutput("tgt_rrsp_wait", 64'(tgt_rrsp), 64'(exp_sel));
      end
      tgt_rvalid  = '0;
      tgt_rdata   = {$urandom, $urandom};
      tgt_act_rsp = 6'($urandom);
      if (tgt >= 0) begin
        tgt_rvalid[1-tgt] = 1'($urandom_range(0, 1));
        if (cyc == delay) begin
          tgt_rvalid[tgt]              = 1'b1;
          tgt_rdata[tgt*RW +: RW]      = rdat;
          tgt_act_rsp[tgt*3 +: 3]      = st;
        end
      end
      csr_rrsp = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    csr_rrsp   = 1'b0;
    tgt_rvalid = '0;

    checkOutput("rsp_latency", 64'(cyc), 64'(exp_cyc));
    checkOutput("csr_rvalid", 64'(csr_rvalid), 64'(1));
    checkOutput("csr_rdata", 64'(csr_rdata), 64'(exp_d));
    checkOutput("csr_reg_rsp", 64'(csr_reg_rsp), 64'(exp_st));

    for (int h = 0; h < hold; h++) begin
      tgt_rvalid  = NT'($urandom);
      tgt_rdata   = {$urandom, $urandom};
      tgt_act_rsp = 6'($urandom);
      @(negedge clk);
      checkOutput("hold_rvalid", 64'(csr_rvalid), 64'(1));
      checkOutput("hold_rdata", 64'(csr_rdata), 64'(exp_d));
      checkOutput("hold_status", 64'(csr_reg_rsp), 64'(exp_st));
      checkOutput("hold_ready", 64'(csr_ready), 64'(0));
    end
    tgt_rvalid = '0;
    csr_rrsp   = 1'b1;
    @(negedge clk);
    csr_rrsp   = 1'b0;
    checkOutput("ready_after_rrsp", 64'(csr_ready), 64'(1));
    checkOutput("rvalid_after_rrsp", 64'(csr_rvalid), 64'(0));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rvalid"}, 64'(csr_rvalid), 64'(0));
    checkOutput({tag, "_rdata"}, 64'(csr_rdata), 64'(0));
    checkOutput({tag, "_status"}, 64'(csr_reg_rsp), 64'(0));
    checkOutput({tag, "_reg_en"}, 64'(tgt_reg_en), 64'(0));
    checkOutput({tag, "_rrsp"}, 64'(tgt_rrsp), 64'(0));
    checkOutput({tag, "_payload"},
                {tgt_addr, tgt_rs1_val} | 64'({tgt_csr_imm, tgt_funct3, tgt_reg_op}),
                64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    edge_addrs = '{32'h2FF, 32'h306, 32'h39F, 32'h3F0, 32'h3A0, 32'h3EF, 32'h300, 32'h305};
    rst_n = 1'b0; csr_valid = 1'b0; csr_op = '0; csr_funct3 = '0; csr_imm = '0;
    rs1_val = '0; csr_addr = '0; csr_rrsp = 1'b0;
    tgt_rvalid = '0; tgt_rdata = '0; tgt_act_rsp = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    checkOutput("reset_ready", 64'(csr_ready), 64'(1));
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed accesses");
    applyStimulus(32'h3A4, 2'b01, 32'hDEAD_BEEF, 3'b001, 5'd0, 2, 32'h0, 3'b000, 0);
    applyStimulus(32'h7C0, 2'b10, 32'h0, 3'b010, 5'd0, 1, 32'h5555_AAAA, 3'b011, 1);
    applyStimulus(32'h302, 2'b10, 32'h0, 3'b010, 5'd3, 1, 32'h1234, 3'b110, 1);
    applyStimulus(32'h3EF, 2'b11, 32'h0F0F_0F0F, 3'b011, 5'd7, 3, 32'hA5A5_5A5A, 3'b000, 5);
`ifdef CSR_XBAR_TIMEOUT_EN
    applyStimulus(32'h3A4, 2'b10, 32'h0, 3'b010, 5'd0, -1, 32'h0, 3'b000, 3);
    applyStimulus(32'h3A0, 2'b10, 32'h0, 3'b010, 5'd0, 2, 32'hCAFE, 3'b000, 0);
`endif

    $display("[TB] reset during wait");
    csr_valid = 1'b1; csr_addr = 32'h3A4; csr_op = 2'b01; rs1_val = 32'h1111_2222;
    @(negedge clk);
    csr_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_ready", 64'(csr_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_reset_ready", 64'(csr_ready), 64'(1));
      checkOutput("post_reset_reg_en", 64'(tgt_reg_en), 64'(0));
    end

    $display("[TB] randomized accesses");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'h3A0 + $urandom_range(0, 32'h4F);
        1:       a = 32'h300 + $urandom_range(0, 5);
        2:       a = edge_addrs[$urandom_range(0, 7)];
        default: a = $urandom;
      endcase
      applyStimulus(a, 2'($urandom), $urandom, 3'($urandom), 5'($urandom),
                    $urandom_range(1, 5), $urandom, 3'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_xbar.md
# csr_xbar

Parametrised CSR request router between the core's CSR execute stage and N CSR target blocks (PMP, AIA, counters, …). It accepts one CSR access at a time with a valid/ready handshake and decodes the address against a per-target base/limit table. It forwards the access to exactly one target, waits for that target's response, and returns read data plus a normal/exception status to the core. Unmapped addresses and, optionally, unresponsive targets produce an exception response instead of hanging the pipeline.

## Interface
- ADDR_WIDTH, 32, CSR address width
- REG_WIDTH, 32, data/rs1 width
- N_TGT, 4, number of targets (1..8)
- TGT_BASE, {N_TGT{32'h0}}, packed N_TGT×ADDR_WIDTH inclusive base addresses; target i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- TGT_LIMIT, {N_TGT{32'h0}}, packed N_TGT×ADDR_WIDTH inclusive limit addresses, same packing
- TIMEOUT_CYC, 16, WAIT cycles before timeout (≥2)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- csr_valid  in  1  request valid
- csr_ready  out  1  router can accept
- csr_op  in  2  [1]=R, [0]=W
- csr_funct3  in  3  CSR funct3
- csr_imm  in  5  zimm
- rs1_val  in  REG_WIDTH  rs1 operand
- csr_addr  in  ADDR_WIDTH  CSR address
- csr_rvalid  out  1  response valid
- csr_rdata  out  REG_WIDTH  read data
- csr_reg_rsp  out  3  [2]=exception, [1:0]=cause
- csr_rrsp  in  1  core accepts response
- tgt_reg_en  out  N_TGT  one-hot access strobe
- tgt_addr / tgt_csr_imm / tgt_rs1_val / tgt_funct3 / tgt_reg_op  out  ADDR_WIDTH/5/REG_WIDTH/3/2  latched request, shared by all targets
- tgt_rvalid  in  N_TGT  per-target response valid
- tgt_rdata  in  N_TGT×REG_WIDTH  per-target read data
- tgt_act_rsp  in  N_TGT×3  per-target status
- tgt_rrsp  out  N_TGT  one-hot response accept

## Operation
- FSM states: IDLE, ISSUE, WAIT, RSP.
- IDLE: csr_ready=1. On csr_valid: latch the payload and decode, then go to ISSUE on a hit or to RSP on a miss. A miss loads status 3'b101 and rdata 0.
- Decode: hit_i = (addr ≥ TGT_BASE[i]) & (addr ≤ TGT_LIMIT[i]). On overlap, the lowest index wins. The selection is held in a registered one-hot sel.
- ISSUE: tgt_reg_en=sel for exactly one cycle, then go to WAIT. The same cycle is also checked for tgt_rvalid&sel, as in WAIT.
- WAIT: tgt_rrsp=sel. When tgt_rvalid[sel] is high, capture tgt_rdata/tgt_act_rsp of the selected target and go to RSP. tgt_rvalid from unselected targets is ignored.
- RSP: csr_rvalid=1 with captured data held stable until csr_rrsp, then go to IDLE. Data/status must not change while csr_rvalid is high.
- Target status passes through unmodified. The router generates only two causes: 2'b01 unmapped and 2'b10 timeout, both with bit 2 set.
- tgt_* payload outputs stay at the latched values until the next accept. All are zero after reset.

## Timing
- Reset: state IDLE; csr_ready=1; csr_rvalid, csr_rdata, csr_reg_rsp, tgt_reg_en, tgt_rrsp and all tgt_* payloads are 0; timeout counter is 0.
- rst_n asserted in any state aborts the access immediately. No target strobe is re-issued after reset.
- Hit latency, with accept at cycle 0: tgt_reg_en at cycle 1. If the target responds at cycle k≥1, csr_rvalid is high at cycle k+1.
- Miss latency: csr_rvalid at cycle 1. No tgt_reg_en is asserted.
- Back-to-back: csr_ready returns to 1 in the cycle after the csr_rrsp handshake. The throughput floor is one access per 3 cycles for a hit.
- csr_rrsp sampled while csr_rvalid=0 is ignored.

## Configuration
- CSR_XBAR_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYC+1) runs in ISSUE and WAIT.
  - When it reaches TIMEOUT_CYC without a response, the router goes to RSP with status 3'b110 and rdata 0.
  - tgt_rrsp drops, and a late target response is ignored.
  - If a response and the timeout occur in the same cycle, the response wins.
- CSR_XBAR_TIMEOUT_EN undefined: no counter is present and WAIT waits indefinitely.

## Structure
- csr_xbar_pkg holds: the state enum, the cause localparams CAUSE_UNMAPPED=2'b01 and CAUSE_TIMEOUT=2'b10, and the status-field width.
- Sub-module csr_xbar_decode: combinational address to one-hot priority hit plus miss flag, parameterised like the parent.

## Test plan
- Configuration for all tests: N_TGT=2, target0 range 12'h3A0–12'h3EF, target1 range 12'h300–12'h305.
- Write to 12'h3A4 with rs1=32'hDEAD_BEEF: tgt_reg_en=2'b01 at cycle 1 with tgt_rs1_val=DEADBEEF. Target0 responds at cycle 2 with status 3'b000. csr_rvalid is high at cycle 3 with status 000.
- Read of 12'h7C0 (unmapped): csr_rvalid at cycle 1 with status 3'b101 and rdata 0. tgt_reg_en stays 0.
- Target1 returns status 3'b110 and rdata 32'h1234: the core sees the same status and rdata, unchanged.
- With TIMEOUT_EN and TIMEOUT_CYC=4, target silent: status 3'b110 and rdata 0. A late tgt_rvalid is ignored and the next request to target0 completes normally.
- Core holds csr_rrsp=0 for 5 cycles in RSP: csr_rvalid and csr_rdata stay stable and csr_ready stays 0. Release completes the access, and a new accept occurs the next cycle.
- rst_n pulsed low during WAIT: all outputs are 0 immediately and csr_ready=1 after release.
